// File: rtl/dma_byp_in_arb.sv
// dma_byp_in_arb: per-channel descriptor FIFOs merged round-robin onto one registered bypass-in stream.
// Defining DMA_BYP_IN_CIDX_CHK_EN adds a per-channel sticky cidx continuity checker (cidx_err).
module dma_byp_in_arb #(
    parameter int  NUM_CH     = 4,
    parameter int  DSC_W      = 256,
    parameter int  CIDX_W     = 16,
    parameter int  FIFO_DEPTH = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*DSC_W-1:0]   s_dsc,
    input  logic [NUM_CH*CIDX_W-1:0]  s_cidx,
    input  logic [NUM_CH-1:0]         s_vld,
    output logic [NUM_CH-1:0]         s_rdy,
    output logic [DSC_W-1:0]          m_dsc,
    output logic [CIDX_W-1:0]         m_cidx,
    output logic [CH_W-1:0]           m_ch,
    output logic                      m_vld,
    input  logic                      m_rdy,
    output logic [NUM_CH*CNT_W-1:0]   fifo_cnt
`ifdef DMA_BYP_IN_CIDX_CHK_EN
    ,
    output logic [NUM_CH-1:0]         cidx_err
`endif
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [DSC_W-1:0]  mem_dsc_q  [NUM_CH][FIFO_DEPTH];
    logic [CIDX_W-1:0] mem_cidx_q [NUM_CH][FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] nonempty;

    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   gnt_ch;
    logic              gnt_vld;
    logic              slot_free;
    logic              take;

    logic              m_vld_q,  m_vld_d;
    logic [DSC_W-1:0]  m_dsc_q,  m_dsc_d;
    logic [CIDX_W-1:0] m_cidx_q, m_cidx_d;
    logic [CH_W-1:0]   m_ch_q,   m_ch_d;

    // Ready depends only on registered occupancy, so a full FIFO never takes a same-cycle push.
    always_comb begin
        nonempty = '0;
        s_rdy    = '0;
        push     = '0;
        fifo_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i]                = (cnt_q[i] != '0);
            s_rdy[i]                   = !rst && (cnt_q[i] != FULL_CNT);
            push[i]                    = s_vld[i] && s_rdy[i];
            fifo_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!gnt_vld && nonempty[(int'(ptr_q) + k) % NUM_CH]) begin
                gnt_vld = 1'b1;
                gnt_ch  = CH_W'((int'(ptr_q) + k) % NUM_CH);
            end
        end
    end

    assign slot_free = !m_vld_q || m_rdy;
    assign take      = slot_free && gnt_vld;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i]      = take && (gnt_ch == CH_W'(i));
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            cnt_d[i]    = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Output slot: reload on every free cycle; payload holds its last value when nothing is granted.
    always_comb begin
        m_vld_d  = m_vld_q;
        m_dsc_d  = m_dsc_q;
        m_cidx_d = m_cidx_q;
        m_ch_d   = m_ch_q;
        ptr_d    = ptr_q;
        if (slot_free) begin
            m_vld_d = gnt_vld;
            if (gnt_vld) begin
                m_dsc_d  = mem_dsc_q[gnt_ch][rd_ptr_q[gnt_ch]];
                m_cidx_d = mem_cidx_q[gnt_ch][rd_ptr_q[gnt_ch]];
                m_ch_d   = gnt_ch;
                ptr_d    = gnt_ch;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            ptr_q    <= CH_W'(NUM_CH - 1);
            m_vld_q  <= 1'b0;
            m_dsc_q  <= '0;
            m_cidx_q <= '0;
            m_ch_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            ptr_q    <= ptr_d;
            m_vld_q  <= m_vld_d;
            m_dsc_q  <= m_dsc_d;
            m_cidx_q <= m_cidx_d;
            m_ch_q   <= m_ch_d;
        end
    end

    // Storage is data-only; validity is tracked entirely by the pointers and counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_dsc_q[i][wr_ptr_q[i]]  <= s_dsc[i*DSC_W +: DSC_W];
                mem_cidx_q[i][wr_ptr_q[i]] <= s_cidx[i*CIDX_W +: CIDX_W];
            end
        end
    end

    assign m_vld  = m_vld_q;
    assign m_dsc  = m_dsc_q;
    assign m_cidx = m_cidx_q;
    assign m_ch   = m_ch_q;

`ifdef DMA_BYP_IN_CIDX_CHK_EN
    logic [CIDX_W-1:0] exp_q  [NUM_CH];
    logic [CIDX_W-1:0] exp_d  [NUM_CH];
    logic [NUM_CH-1:0] seen_q, seen_d;
    logic [NUM_CH-1:0] err_q,  err_d;

    // First accepted beat after reset only seeds the expectation; later beats must step by one.
    always_comb begin
        seen_d = seen_q;
        err_d  = err_q;
        for (int i = 0; i < NUM_CH; i++) begin
            exp_d[i] = exp_q[i];
            if (push[i]) begin
                if (seen_q[i] && (s_cidx[i*CIDX_W +: CIDX_W] != exp_q[i] + CIDX_W'(1))) begin
                    err_d[i] = 1'b1;
                end
                exp_d[i]  = s_cidx[i*CIDX_W +: CIDX_W];
                seen_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= '0;
            err_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                exp_q[i] <= '0;
            end
        end else begin
            seen_q <= seen_d;
            err_q  <= err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                exp_q[i] <= exp_d[i];
            end
        end
    end

    assign cidx_err = err_q;
`endif

endmodule

// File: tb/tb_dma_byp_in_arb.sv
// tb_dma_byp_in_arb: table vectors plus scoreboard-checked sequences for dma_byp_in_arb.
module tb_dma_byp_in_arb;

    localparam int NUM_CH     = 4;
    localparam int DSC_W      = 256;
    localparam int CIDX_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CH_W       = 2;
    localparam int CNT_W      = 3;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH*DSC_W-1:0]  s_dsc;
    logic [NUM_CH*CIDX_W-1:0] s_cidx;
    logic [NUM_CH-1:0]        s_vld;
    logic [NUM_CH-1:0]        s_rdy;
    logic [DSC_W-1:0]         m_dsc;
    logic [CIDX_W-1:0]        m_cidx;
    logic [CH_W-1:0]          m_ch;
    logic                     m_vld;
    logic                     m_rdy;
    logic [NUM_CH*CNT_W-1:0]  fifo_cnt;
`ifdef DMA_BYP_IN_CIDX_CHK_EN
    logic [NUM_CH-1:0]        cidx_err;
`endif

    dma_byp_in_arb #(
        .NUM_CH(NUM_CH), .DSC_W(DSC_W), .CIDX_W(CIDX_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_dsc(s_dsc), .s_cidx(s_cidx), .s_vld(s_vld), .s_rdy(s_rdy),
        .m_dsc(m_dsc), .m_cidx(m_cidx), .m_ch(m_ch), .m_vld(m_vld), .m_rdy(m_rdy),
        .fifo_cnt(fifo_cnt)
`ifdef DMA_BYP_IN_CIDX_CHK_EN
        , .cidx_err(cidx_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DSC_W-1:0]  dsc;
        logic [CIDX_W-1:0] cidx;
    } beat_t;

    typedef struct {
        int                ch;
        logic [DSC_W-1:0]  dsc;
        logic [CIDX_W-1:0] cidx;
    } vec_t;

    beat_t sb[NUM_CH][$];
    int    exp_ch[$];
    int    errors = 0;
    int    checks = 0;
    int    out_cnt = 0;

    task automatic chk(input string name, input logic [DSC_W-1:0] act, input logic [DSC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DSC_W-1:0] mk(input int ch, input int n);
        logic [7:0] b;
        b = 8'(ch * 16 + n);
        return {32{b}};
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return fifo_cnt[ch*CNT_W +: CNT_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int ch, input logic [DSC_W-1:0] d, input logic [CIDX_W-1:0] c);
        s_dsc[ch*DSC_W +: DSC_W]    = d;
        s_cidx[ch*CIDX_W +: CIDX_W] = c;
        s_vld[ch]                   = 1'b1;
    endtask

    function automatic int sb_pending();
        int n;
        n = exp_ch.size();
        for (int i = 0; i < NUM_CH; i++) n += sb[i].size();
        return n;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_pending() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, DSC_W'(sb_pending()), '0);
    endtask

    // Scoreboard: record accepted pushes, compare every delivered beat.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (s_vld[i] && s_rdy[i]) begin
                    beat_t b;
                    b.dsc  = s_dsc[i*DSC_W +: DSC_W];
                    b.cidx = s_cidx[i*CIDX_W +: CIDX_W];
                    sb[i].push_back(b);
                end
            end
            if (m_vld && m_rdy) begin
                beat_t e;
                out_cnt++;
                if (sb[m_ch].size() == 0) begin
                    chk("sb_unexpected_beat", DSC_W'(m_ch) + 1, '0);
                end else begin
                    e = sb[m_ch].pop_front();
                    chk("sb_dsc", m_dsc, e.dsc);
                    chk("sb_cidx", DSC_W'(m_cidx), DSC_W'(e.cidx));
                end
                if (exp_ch.size() != 0) begin
                    chk("sb_rr_ch", DSC_W'(m_ch), DSC_W'(exp_ch.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   base;
        vecs[0] = '{0, {32{8'hA5}}, 16'h0010};
        vecs[1] = '{2, {32{8'h3C}}, 16'h0001};
        vecs[2] = '{1, {32{8'h5A}}, 16'h1234};
        vecs[3] = '{3, {32{8'hFF}}, 16'hFFFF};

        rst    = 1'b1;
        s_dsc  = '0;
        s_cidx = '0;
        s_vld  = '0;
        m_rdy  = 1'b0;
        tick();
        tick();
        chk("rst_m_vld", DSC_W'(m_vld), '0);
        chk("rst_m_dsc", m_dsc, '0);
        chk("rst_m_cidx", DSC_W'(m_cidx), '0);
        chk("rst_m_ch", DSC_W'(m_ch), '0);
        chk("rst_fifo_cnt", DSC_W'(fifo_cnt), '0);
        chk("rst_s_rdy", DSC_W'(s_rdy), '0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_rdy", DSC_W'(s_rdy), DSC_W'(4'hF));

        // Single-beat vectors: two-edge latency, tag and payload, count returns to zero.
        m_rdy = 1'b1;
        for (int v = 0; v < 4; v++) begin
            set_beat(vecs[v].ch, vecs[v].dsc, vecs[v].cidx);
            tick();
            s_vld = '0;
            chk("vec_cnt_after_push", DSC_W'(cnt_of(vecs[v].ch)), 1);
            chk("vec_m_vld_early", DSC_W'(m_vld), '0);
            tick();
            chk("vec_m_vld", DSC_W'(m_vld), 1);
            chk("vec_m_ch", DSC_W'(m_ch), DSC_W'(vecs[v].ch));
            chk("vec_m_cidx", DSC_W'(m_cidx), DSC_W'(vecs[v].cidx));
            chk("vec_m_dsc", m_dsc, vecs[v].dsc);
            chk("vec_cnt_after_pop", DSC_W'(cnt_of(vecs[v].ch)), '0);
            tick();
            chk("vec_m_vld_idle", DSC_W'(m_vld), '0);
            chk("vec_m_ch_hold", DSC_W'(m_ch), DSC_W'(vecs[v].ch));
        end

        // All channels, 3 beats each, round-robin interleave starting at ch0.
        for (int n = 0; n < 3; n++)
            for (int c = 0; c < NUM_CH; c++) exp_ch.push_back(c);
        base = out_cnt;
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < NUM_CH; c++) set_beat(c, mk(c, n), 16'(c * 256 + n));
            tick();
        end
        s_vld = '0;
        drain("rr_drain", 40);
        chk("rr_beats", DSC_W'(out_cnt - base), 12);
        tick();
        chk("rr_idle_m_vld", DSC_W'(m_vld), '0);

        // Backpressure: ch2 fills slot + FIFO, sixth beat refused, slot held stable.
        m_rdy = 1'b0;
        base  = out_cnt;
        for (int n = 0; n < 6; n++) begin
            set_beat(2, mk(2, n), 16'(16'h0203 + n));
            tick();
            if (n >= 1) begin
                chk("bp_m_vld", DSC_W'(m_vld), 1);
                chk("bp_m_dsc_stable", m_dsc, mk(2, 0));
                chk("bp_m_cidx_stable", DSC_W'(m_cidx), DSC_W'(16'h0203));
                chk("bp_m_ch_stable", DSC_W'(m_ch), 2);
            end
            if (n == 4) chk("bp_s_rdy_full", DSC_W'(s_rdy[2]), '0);
        end
        s_vld = '0;
        chk("bp_cnt_full", DSC_W'(cnt_of(2)), FIFO_DEPTH);
        chk("bp_s_rdy_still_full", DSC_W'(s_rdy[2]), '0);
        m_rdy = 1'b1;
        drain("bp_drain", 40);
        tick();
        tick();
        chk("bp_beats", DSC_W'(out_cnt - base), 5);
        chk("bp_cnt_empty", DSC_W'(cnt_of(2)), '0);

        // Async reset mid-burst drops buffered and held beats.
        m_rdy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_beat(0, mk(0, n + 8), 16'(16'h0050 + n));
            tick();
        end
        s_vld = '0;
        chk("mr_cnt_before", DSC_W'(cnt_of(0)), 2);
        chk("mr_m_vld_before", DSC_W'(m_vld), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_m_vld", DSC_W'(m_vld), '0);
        chk("mr_fifo_cnt", DSC_W'(fifo_cnt), '0);
        chk("mr_s_rdy", DSC_W'(s_rdy), '0);
        for (int i = 0; i < NUM_CH; i++) sb[i].delete();
        exp_ch.delete();
        tick();
        rst   = 1'b0;
        m_rdy = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("mr_no_stale", DSC_W'(m_vld), '0);
        end

        // cidx wrap on ch1 passes through in order.
        exp_ch.push_back(1);
        exp_ch.push_back(1);
        exp_ch.push_back(1);
        set_beat(1, mk(1, 1), 16'hFFFE);
        tick();
        set_beat(1, mk(1, 2), 16'hFFFF);
        tick();
        set_beat(1, mk(1, 3), 16'h0000);
        tick();
        s_vld = '0;
        drain("wrap_drain", 20);
`ifdef DMA_BYP_IN_CIDX_CHK_EN
        chk("wrap_cidx_err", DSC_W'(cidx_err[1]), '0);

        // ch3 jumps 5 -> 7: sticky error, both beats still delivered.
        exp_ch.push_back(3);
        exp_ch.push_back(3);
        set_beat(3, mk(3, 5), 16'd5);
        tick();
        s_vld = '0;
        tick();
        chk("err_before", DSC_W'(cidx_err[3]), '0);
        set_beat(3, mk(3, 7), 16'd7);
        tick();
        s_vld = '0;
        chk("err_set", DSC_W'(cidx_err[3]), 1);
        chk("err_other_ch", DSC_W'(cidx_err[2:0]), '0);
        drain("err_drain", 20);
        tick();
        tick();
        chk("err_sticky", DSC_W'(cidx_err[3]), 1);
`endif

        chk("final_sb_empty", DSC_W'(sb_pending()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_byp_in_arb.md
Name: dma_byp_in_arb

Overview:
- Parametrised N-channel descriptor bypass-in aggregator.
- Each channel presents {dsc, cidx, vld/rdy} and is buffered in its own small FIFO.
- A round-robin arbiter merges the channels onto one registered bypass-in stream, tagged with the source channel.
- Sits between the per-queue descriptor sources and the DMA engine's single bypass-in port.

Parameters:
- NUM_CH, 4, number of input channels (1..16).
- DSC_W, 256, descriptor width in bits.
- CIDX_W, 16, consumer-index width in bits.
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2).
- Derived: CH_W = max(1, clog2(NUM_CH)).
- Derived: CNT_W = clog2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- s_dsc  in  NUM_CH*DSC_W  per-channel descriptor; channel i at [i*DSC_W +: DSC_W].
- s_cidx  in  NUM_CH*CIDX_W  per-channel consumer index.
- s_vld  in  NUM_CH  per-channel valid.
- s_rdy  out  NUM_CH  per-channel ready.
- m_dsc  out  DSC_W  merged descriptor.
- m_cidx  out  CIDX_W  merged consumer index.
- m_ch  out  CH_W  source channel of the current m_* beat.
- m_vld  out  1  output valid.
- m_rdy  in  1  output ready.
- fifo_cnt  out  NUM_CH*CNT_W  per-channel occupancy, registered.

Behaviour:
- Reset (async assert, sync release):
  - All FIFOs emptied; fifo_cnt = 0.
  - m_vld = 0; m_dsc, m_cidx and m_ch = 0.
  - RR pointer = NUM_CH-1, so channel 0 wins first.
  - s_rdy = 0 while rst is high.
- Reset asserted mid-operation drops all buffered beats and any held output beat. No partial beat survives.
- Input handshake, per channel:
  - s_rdy[i] = (fifo_cnt[i] != FIFO_DEPTH), driven from registered count only; no combinational path from m_rdy or s_vld.
  - A push occurs on each edge where s_vld[i] & s_rdy[i].
  - A full FIFO does not accept a push, even if it is popped in the same cycle.
- Output stage: single register slot holding {dsc, cidx, ch}.
  - Slot is "free" when !m_vld or (m_vld & m_rdy).
  - When free and at least one FIFO is non-empty, the arbiter grants one channel. Its head is popped and loaded into the slot on that edge, and m_vld = 1.
  - When free and all FIFOs are empty, m_vld goes to 0 on the edge. m_dsc, m_cidx and m_ch hold their last values.
  - While m_vld & !m_rdy, all m_* signals are held stable and no pop occurs.
- Arbitration, round-robin:
  - Search order is ptr+1, ptr+2, ... wrapping modulo NUM_CH. The first non-empty channel wins.
  - ptr updates to the granted channel only on a grant.
  - NUM_CH=1 degenerates to a plain FIFO plus register, with m_ch = 0.
- Latency and throughput:
  - A beat pushed on edge E into an empty FIFO, with a free slot and no contention, appears on m_vld after edge E+1.
  - Sustained throughput is 1 beat/cycle with m_rdy held high.
- Ordering: per-channel order is preserved. Cross-channel order is defined only by RR.
- fifo_cnt per edge: +1 on push, -1 on pop, unchanged on both or neither. Never exceeds FIFO_DEPTH and never underflows.
- FIFO pointers: clog2(FIFO_DEPTH) bits, wrap naturally.

Optional Feature:
- Macro: DMA_BYP_IN_CIDX_CHK_EN.
- With macro defined:
  - Adds output port cidx_err out NUM_CH.
  - Each channel keeps an expected-cidx register, loaded from the first accepted beat after reset.
  - Each later accepted beat is compared to expected+1 mod 2^CIDX_W. On mismatch, cidx_err[i] is set the cycle after the push and stays sticky until rst.
  - The expected register always updates to the received cidx.
  - Data flow is unaffected.
- Without macro: port and checker logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, then ch0 push dsc=0xA5..A5, cidx=0x0010 -> m_vld=1 two edges later with m_ch=0, m_cidx=0x0010; fifo_cnt[0] returns to 0.
- All 4 channels push 3 beats each simultaneously, m_rdy=1 -> output m_ch sequence 0,1,2,3,0,1,2,3,0,1,2,3 with per-channel cidx order intact.
- m_rdy=0, ch2 pushes 5 beats -> 1 beat is in the output slot and 4 in FIFO. fifo_cnt[2]=4 and s_rdy[2]=0, and the 6th beat is not accepted. m_* is stable throughout. Releasing m_rdy drains 5 beats.
- Async rst asserted mid-burst with 3 beats buffered -> m_vld=0 and fifo_cnt=0 immediately. After release, no stale beat is emitted.
- cidx wrap on ch1: 0xFFFE, 0xFFFF, 0x0000 -> all beats emitted in order; with DMA_BYP_IN_CIDX_CHK_EN, cidx_err[1] stays 0.
- With DMA_BYP_IN_CIDX_CHK_EN, ch3 cidx 5 then 7 -> cidx_err[3]=1 one cycle after the second push, sticky. Both beats are still delivered.
